// File: rtl/soc_run_monitor_if.sv
// soc_run_monitor_if: host/CPU/trace/readout signal bundle for the run monitor.
interface soc_run_monitor_if #(
    parameter int W     = 16,
    parameter int DEPTH = 16
);
    logic                     start_in;
    logic                     cpu_start;
    logic                     cpu_finish;
    logic                     trace_valid;
    logic [W-1:0]             trace_data;
    logic                     rd_en;
    logic [W-1:0]             rd_data;
    logic                     rd_valid;
    logic [$clog2(DEPTH):0]   count;
    logic                     busy;
    logic                     done;
    logic                     timeout;
    logic                     overflow;

    modport master (
        output start_in, cpu_finish, trace_valid, trace_data, rd_en,
        input  cpu_start, rd_data, rd_valid, count, busy, done, timeout, overflow
    );

    modport slave (
        input  start_in, cpu_finish, trace_valid, trace_data, rd_en,
        output cpu_start, rd_data, rd_valid, count, busy, done, timeout, overflow
    );
endinterface

// File: rtl/soc_run_monitor.sv
// soc_run_monitor: launches a CPU run, captures its trace into a circular buffer, flags done/timeout.
module soc_run_monitor #(
    parameter int W       = 16,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 500
) (
    input logic               clk,
    input logic               rst_b,
    soc_run_monitor_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DONE, TMO} state_t;

    state_t          state;
    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TW-1:0]   timer;
    logic            wr;

    always_comb wr = (state == RUN) && bus.trace_valid;

    always_ff @(posedge clk)
        if (wr) mem[wr_ptr] <= bus.trace_data;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            timer        <= '0;
            bus.cpu_start <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            bus.count    <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.timeout  <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            bus.cpu_start <= 1'b0;
            bus.rd_valid  <= 1'b0;
            case (state)
                IDLE, DONE, TMO: begin
                    // a new start takes priority over a pending readout
                    if (bus.start_in) begin
                        state         <= LAUNCH;
                        bus.cpu_start <= 1'b1;
                        bus.busy      <= 1'b1;
                        wr_ptr        <= '0;
                        rd_ptr        <= '0;
                        timer         <= '0;
                        bus.count     <= '0;
                        bus.done      <= 1'b0;
                        bus.timeout   <= 1'b0;
                        bus.overflow  <= 1'b0;
                    end else if (bus.rd_en && state != IDLE && bus.count != '0) begin
                        bus.rd_data  <= mem[rd_ptr];
                        bus.rd_valid <= 1'b1;
                        rd_ptr       <= rd_ptr + AW'(1);
                        bus.count    <= bus.count - (AW+1)'(1);
                    end
                end
                LAUNCH: state <= RUN;
                RUN: begin
                    if (wr) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        // full buffer drops its oldest word to keep the newest
                        if (bus.count == (AW+1)'(DEPTH)) begin
                            rd_ptr       <= rd_ptr + AW'(1);
                            bus.overflow <= 1'b1;
                        end else begin
                            bus.count <= bus.count + (AW+1)'(1);
                        end
                    end
                    if (bus.cpu_finish) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        state       <= TMO;
                        bus.timeout <= 1'b1;
                        bus.busy    <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_soc_run_monitor.sv
// tb_soc_run_monitor: directed scenarios plus random traffic against a queue-based reference model.
module tb_soc_run_monitor;
    localparam int W = 16, DEPTH = 16, TIMEOUT = 500;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    soc_run_monitor_if #(.W(W), .DEPTH(DEPTH)) bus ();
    soc_run_monitor #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));

    int errors = 0, checks = 0, pulses = 0;

    // model: phase 0 idle, 1 launch, 2 run, 3 done, 4 timed out
    int           phase = 0;
    int           run_cycles = 0;
    logic [W-1:0] q[$];
    logic         e_start = 0, e_done = 0, e_tmo = 0, e_ovf = 0, e_rdv = 0;
    logic [W-1:0] e_rdata = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_b) begin
            phase = 0; run_cycles = 0; q.delete();
            e_start = 0; e_done = 0; e_tmo = 0; e_ovf = 0; e_rdv = 0; e_rdata = '0;
        end else begin
            e_start = 0;
            e_rdv = 0;
            if (phase == 0 || phase == 3 || phase == 4) begin
                if (bus.start_in) begin
                    phase = 1; q.delete(); run_cycles = 0;
                    e_done = 0; e_tmo = 0; e_ovf = 0; e_start = 1;
                end else if (bus.rd_en && phase != 0 && q.size() > 0) begin
                    e_rdata = q.pop_front();
                    e_rdv = 1;
                end
            end else if (phase == 1) begin
                phase = 2;
            end else begin
                run_cycles++;
                if (bus.trace_valid) begin
                    q.push_back(bus.trace_data);
                    if (q.size() > DEPTH) begin
                        void'(q.pop_front());
                        e_ovf = 1;
                    end
                end
                if (bus.cpu_finish) begin
                    phase = 3; e_done = 1;
                end else if (run_cycles == TIMEOUT) begin
                    phase = 4; e_tmo = 1;
                end
            end
        end
        #2;
        pulses += int'(bus.cpu_start);
        chk("m_cpu_start", bus.cpu_start, e_start);
        chk("m_busy", bus.busy, phase == 1 || phase == 2);
        chk("m_done", bus.done, e_done);
        chk("m_timeout", bus.timeout, e_tmo);
        chk("m_overflow", bus.overflow, e_ovf);
        chk("m_count", bus.count, q.size());
        chk("m_rd_valid", bus.rd_valid, e_rdv);
        chk("m_rd_data", bus.rd_data, e_rdata);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_in();
        bus.start_in = 0; bus.cpu_finish = 0; bus.trace_valid = 0; bus.trace_data = '0; bus.rd_en = 0;
    endtask

    // returns with the DUT in RUN and the next inputs landing in RUN cycle 0
    task automatic launch();
        bus.start_in = 1;
        cyc();
        bus.start_in = 0;
        chk("launch_pulse", bus.cpu_start, 1);
        cyc();
        chk("launch_pulse_end", bus.cpu_start, 0);
        chk("launch_busy", bus.busy, 1);
    endtask

    task automatic read_expect(logic [W-1:0] v);
        bus.rd_en = 1;
        cyc();
        bus.rd_en = 0;
        chk("rd_valid", bus.rd_valid, 1);
        chk("rd_word", bus.rd_data, v);
    endtask

    initial begin
        int n, p0;
        idle_in();
        repeat (2) cyc();
        chk("rst_count", bus.count, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        rst_b = 1;

        // basic run: three traces, finish on RUN cycle 5
        p0 = pulses;
        launch();
        for (int k = 0; k < 6; k++) begin
            bus.trace_valid = k < 3;
            bus.trace_data = W'((k + 1) * 'h11);
            bus.cpu_finish = k == 5;
            cyc();
        end
        idle_in();
        chk("basic_done", bus.done, 1);
        chk("basic_busy", bus.busy, 0);
        chk("basic_count", bus.count, 3);
        chk("basic_pulses", pulses - p0, 1);
        read_expect('h0011);
        read_expect('h0022);
        read_expect('h0033);
        chk("basic_drained", bus.count, 0);

        // start/read requests during RUN are ignored; start in DONE relaunches
        p0 = pulses;
        launch();
        bus.start_in = 1; bus.rd_en = 1;
        repeat (3) begin
            cyc();
            chk("run_no_restart", bus.cpu_start, 0);
            chk("run_no_read", bus.rd_valid, 0);
        end
        idle_in();
        bus.cpu_finish = 1;
        cyc();
        idle_in();
        chk("ign_done", bus.done, 1);
        chk("ign_pulses", pulses - p0, 1);
        bus.start_in = 1;
        cyc();
        bus.start_in = 0;
        chk("relaunch_done_clr", bus.done, 0);
        chk("relaunch_pulse", bus.cpu_start, 1);
        cyc();

        // no finish: timeout exactly TIMEOUT cycles after RUN entry
        n = 0;
        while (!bus.timeout && n < 600) begin
            cyc();
            n++;
        end
        chk("tmo_cycles", n, TIMEOUT);
        chk("tmo_busy", bus.busy, 0);
        chk("tmo_done", bus.done, 0);

        // overflow: 20 traces into a 16-deep buffer
        launch();
        for (int i = 1; i <= 20; i++) begin
            bus.trace_valid = 1;
            bus.trace_data = W'(i);
            cyc();
        end
        idle_in();
        bus.cpu_finish = 1;
        cyc();
        idle_in();
        chk("ovf_flag", bus.overflow, 1);
        chk("ovf_count", bus.count, 16);
        for (int i = 5; i <= 20; i++) read_expect(W'(i));

        // finish on the last allowed cycle beats the timeout
        launch();
        for (int k = 0; k < TIMEOUT; k++) begin
            bus.trace_valid = k < 3;
            bus.trace_data = W'('h100 + k);
            bus.cpu_finish = k == TIMEOUT - 1;
            cyc();
        end
        idle_in();
        chk("edge_done", bus.done, 1);
        chk("edge_timeout", bus.timeout, 0);
        read_expect('h100);
        read_expect('h101);
        read_expect('h102);
        bus.rd_en = 1;
        cyc();
        bus.rd_en = 0;
        chk("empty_rd_valid", bus.rd_valid, 0);
        chk("empty_rd_hold", bus.rd_data, 'h102);

        // asynchronous reset mid-run discards everything
        launch();
        for (int k = 0; k < 4; k++) begin
            bus.trace_valid = 1;
            bus.trace_data = W'('hA0 + k);
            cyc();
        end
        idle_in();
        cyc();
        rst_b = 0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_count", bus.count, 0);
        chk("arst_rd_data", bus.rd_data, 0);
        chk("arst_start", bus.cpu_start, 0);
        cyc();
        rst_b = 1;
        p0 = pulses;
        repeat (3) cyc();
        chk("arst_no_pulse", pulses - p0, 0);
        launch();
        bus.cpu_finish = 1;
        cyc();
        idle_in();
        chk("arst_fresh_count", bus.count, 0);

        // random traffic checked by the model
        repeat (4000) begin
            bus.start_in = $urandom_range(0, 39) == 0;
            bus.cpu_finish = $urandom_range(0, 59) == 0;
            bus.trace_valid = $urandom_range(0, 1) == 1;
            bus.trace_data = W'($urandom);
            bus.rd_en = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 999) == 0) begin
                rst_b = 0;
                cyc();
                rst_b = 1;
            end
            cyc();
        end
        idle_in();
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/soc_run_monitor.md
SOC_RUN_MONITOR -- requirements
Module: soc_run_monitor

Interface
REQ-001 SHALL have parameter W, default 16, trace word width.
REQ-002 SHALL have parameter DEPTH, default 16, trace buffer entries (power of 2, >=2).
REQ-003 SHALL have parameter TIMEOUT, default 500, RUN-cycle limit (>=2).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_b  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_in  input  1  host run request (level sampled per cycle).
REQ-007 SHALL have port cpu_start  output  1  one-cycle start pulse to CPU.
REQ-008 SHALL have port cpu_finish  input  1  CPU completion indication.
REQ-009 SHALL have port trace_valid  input  1  trace word present this cycle.
REQ-010 SHALL have port trace_data  input  W  trace word (e.g. state/PC snapshot).
REQ-011 SHALL have port rd_en  input  1  readout request.
REQ-012 SHALL have port rd_data  output  W  oldest buffered word, registered.
REQ-013 SHALL have port rd_valid  output  1  rd_data valid this cycle.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  words held.
REQ-015 SHALL have ports busy, done, timeout, overflow  output  1 each  status flags.

Function
REQ-016 SHALL implement FSM IDLE, LAUNCH, RUN, DONE, TMO.
REQ-017 IDLE/DONE/TMO: start_in=1 -> LAUNCH; clears buffer pointers, count, cycle timer, done, timeout, overflow.
REQ-018 LAUNCH: cpu_start=1 for exactly this cycle -> RUN next cycle; start_in ignored.
REQ-019 RUN: timer increments each cycle from 0; busy=1 in LAUNCH and RUN only.
REQ-020 RUN, cpu_finish=1 -> DONE, done=1 sticky.
REQ-021 RUN, cpu_finish=0 and timer==TIMEOUT-1 -> TMO, timeout=1 sticky.
REQ-022 finish and timeout limit in same cycle -> DONE wins; timeout stays 0.
REQ-023 start_in during RUN ignored; cpu_finish outside RUN ignored.
REQ-024 RUN, trace_valid=1: trace_data written at write pointer, pointer wraps mod DEPTH; includes the cycle cpu_finish is seen.
REQ-025 Write when count==DEPTH: overwrites oldest, read pointer advances, count stays DEPTH, overflow=1 sticky.
REQ-026 trace_valid outside RUN ignored.
REQ-027 rd_en honoured only in DONE/TMO; count>0 -> next cycle rd_data=oldest word, rd_valid=1, count decrements, read pointer wraps mod DEPTH.
REQ-028 rd_en with count==0 or outside DONE/TMO -> rd_valid=0, no state change, rd_data holds.
REQ-029 rd_en and start_in same cycle in DONE/TMO -> start wins, no read performed.
REQ-030 Readout order SHALL be capture order (oldest first).

Reset
REQ-031 rst_b=0 asynchronously forces IDLE; cpu_start, rd_valid, busy, done, timeout, overflow=0; count=0; rd_data=0; pointers, timer=0.
REQ-032 Reset mid-RUN SHALL abort run and discard buffer; no cpu_start until new start_in after release.
REQ-033 First start_in SHALL be accepted on first rising edge after rst_b deasserts.

Verification
REQ-034 start_in 1 cycle, 3 trace words 0x0011/0x0022/0x0033, cpu_finish at RUN cycle 5 -> one cpu_start pulse, done=1, count=3, three rd_en -> 0x0011,0x0022,0x0033 with rd_valid, count=0.
REQ-035 Run with no cpu_finish -> TMO exactly TIMEOUT (500) cycles after RUN entry, timeout=1, busy=0, done=0.
REQ-036 DEPTH=16, 20 consecutive traces 1..20 then finish -> overflow=1, count=16, readout 5..20.
REQ-037 cpu_finish asserted on RUN cycle TIMEOUT-1 -> DONE, timeout=0; fourth rd_en after 3-word readout -> rd_valid=0.
REQ-038 rst_b pulsed low mid-RUN with 4 words captured -> all outputs 0 immediately, count=0; new start_in -> fresh run, cpu_start pulse.
REQ-039 start_in during RUN and rd_en during RUN -> no second cpu_start, rd_valid=0; start_in in DONE -> new run, flags cleared.
